// File: rtl/loopback_xform.sv
`default_nettype none
// ============================================================================
//  Module   : loopback_xform
//  Brief    : Application-side byte engine behind usb_cdc. Accepts OUT bytes,
//             optionally transforms them, buffers them in a first-word
//             fall-through FIFO and returns them on the IN stream. Drives a
//             stretched activity LED.
//  Options  : define LOOPBACK_XFORM_EN to enable the character transform
//             (A-Z -> a-z, digits rotated up by one); otherwise the block
//             is a pure loopback FIFO with identical timing.
//  Revision : 1.0  initial release
// ============================================================================
module loopback_xform #(
    parameter int DEPTH    = 16,
    parameter int LED_BITS = 20
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [7:0]               out_data_i,
    input  logic                     out_valid_i,
    output logic                     out_ready_o,
    output logic [7:0]               in_data_o,
    output logic                     in_valid_o,
    input  logic                     in_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     led_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    // Storage is deliberately not reset; content after reset is undefined.
    logic [7:0]          mem_q [DEPTH];

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q,  count_d;
    logic [LED_BITS-1:0] led_cnt_q, led_cnt_d;
    logic                rdy_en_q, rdy_en_d;

    logic                w_wr_en;
    logic                w_rd_en;
    logic [7:0]          w_wr_data;

`ifdef LOOPBACK_XFORM_EN
    // Uppercase letters fold to lowercase, digits rotate 0->1 ... 9->0.
    function automatic logic [7:0] xform(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b >= 8'h41 && b <= 8'h5A)
            r = b + 8'h20;
        else if (b >= 8'h30 && b <= 8'h38)
            r = b + 8'h01;
        else if (b == 8'h39)
            r = 8'h30;
        return r;
    endfunction

    // Transform sits on the write side so the read path stays a plain mux.
    always_comb begin
        w_wr_data = xform(out_data_i);
    end
`else
    // Pure loopback: bytes are stored unchanged.
    always_comb begin
        w_wr_data = out_data_i;
    end
`endif

    // Handshake outputs depend only on registered state, never on the peer's ready.
    always_comb begin
        out_ready_o = rdy_en_q & (count_q != C_FULL);
        in_valid_o  = (count_q != '0);
        in_data_o   = mem_q[rd_ptr_q];
        count_o     = count_q;
        led_o       = (led_cnt_q != '0);
        w_wr_en     = out_valid_i & out_ready_o;
        w_rd_en     = in_valid_o & in_ready_i;
    end

    // Next-state for pointers, occupancy, ready-enable and the LED stretcher.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        led_cnt_d = led_cnt_q;
        rdy_en_d  = 1'b1;

        if (w_wr_en)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_rd_en)
            rd_ptr_d = rd_ptr_q + AW'(1);

        case ({w_wr_en, w_rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (w_wr_en || w_rd_en)
            led_cnt_d = '1;
        else if (led_cnt_q != '0)
            led_cnt_d = led_cnt_q - LED_BITS'(1);
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            led_cnt_q <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            led_cnt_q <= led_cnt_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        if (w_wr_en)
            mem_q[wr_ptr_q] <= w_wr_data;
    end

endmodule
`default_nettype wire
